// File: rtl/aes_sbox_table_bank.sv
// Double-buffered masked AES S-box table store: lookups read the active bank
// while the shadow bank is refilled for a new combined mask and direction.

module aes_sbox_lane #(
  parameter int ENTRIES_PER_CYCLE = 16,
  parameter int CTR_W             = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [CTR_W-1:0] ctr,
  input  logic [7:0]       mc,
  input  logic             dir,
  input  logic             rd_bank,
  input  logic [7:0]       addr,
  output logic [7:0]       rd_data
);

  logic [7:0] tbl [2][256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] r;
    y = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      y = gmul(y, y);
      r = gmul(r, y);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] masked_entry(input logic [7:0] a, input logic [7:0] m,
                                              input logic d);
    return (d ? sbox_inv(a ^ m) : sbox_fwd(a ^ m)) ^ m;
  endfunction

  // Table storage is deliberately not reset; bank validity lives in the control logic.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int e = 0; e < ENTRIES_PER_CYCLE; e++) begin
        tbl[wr_bank][8'(int'(ctr) * ENTRIES_PER_CYCLE + e)] <=
          masked_entry(8'(int'(ctr) * ENTRIES_PER_CYCLE + e), mc, dir);
      end
    end
  end

  assign rd_data = tbl[rd_bank][addr];

endmodule

module aes_sbox_table_bank #(
  parameter int NUM_LANES         = 16,
  parameter int ENTRIES_PER_CYCLE = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  output logic                      start_ready_o,
  input  logic                      enc_dec_i,
  input  logic [NUM_LANES-1:0][7:0] mc_i,
  input  logic                      abort_i,
  input  logic                      swap_i,
  output logic                      busy_o,
  output logic                      fill_done_o,
  output logic                      shadow_ready_o,
  output logic                      active_valid_o,
  output logic                      active_dec_o,
  input  logic [NUM_LANES-1:0][7:0] addr_i,
  output logic [NUM_LANES-1:0][7:0] data_o
);

  localparam int FILL_CYCLES = 256 / ENTRIES_PER_CYCLE;
  localparam int CTR_W       = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(FILL_CYCLES - 1);

  logic [NUM_LANES-1:0][7:0] mc_q;
  logic [NUM_LANES-1:0][7:0] lane_rd;
  logic [CTR_W-1:0]          ctr;
  logic                      dir_q;
  logic                      bank_sel;
  logic                      swap_pend;
  logic                      fill_we;

  assign start_ready_o = ~busy_o;
  assign fill_we       = busy_o & ~abort_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o         <= 1'b0;
      fill_done_o    <= 1'b0;
      shadow_ready_o <= 1'b0;
      active_valid_o <= 1'b0;
      active_dec_o   <= 1'b0;
      bank_sel       <= 1'b0;
      swap_pend      <= 1'b0;
      ctr            <= '0;
      mc_q           <= '0;
      dir_q          <= 1'b0;
    end else begin
      fill_done_o <= 1'b0;
      if (abort_i) begin
        busy_o         <= 1'b0;
        shadow_ready_o <= 1'b0;
        swap_pend      <= 1'b0;
        ctr            <= '0;
      end else begin
        if (busy_o) begin
          ctr <= (ctr == CTR_LAST) ? '0 : ctr + 1'b1;
          if (swap_i) swap_pend <= 1'b1;
          if (ctr == CTR_LAST) begin
            busy_o      <= 1'b0;
            fill_done_o <= 1'b1;
            swap_pend   <= 1'b0;
            // A swap requested during the fill lands on the completion edge.
            if (swap_pend || swap_i) begin
              bank_sel       <= ~bank_sel;
              active_valid_o <= 1'b1;
              active_dec_o   <= dir_q;
            end else begin
              shadow_ready_o <= 1'b1;
            end
          end
        end else if (swap_i && shadow_ready_o) begin
          bank_sel       <= ~bank_sel;
          active_valid_o <= 1'b1;
          active_dec_o   <= dir_q;
          shadow_ready_o <= 1'b0;
        end
        // dir_q is read by the swap above before this update lands.
        if (start_i && !busy_o) begin
          mc_q           <= mc_i;
          dir_q          <= enc_dec_i;
          busy_o         <= 1'b1;
          ctr            <= '0;
          shadow_ready_o <= 1'b0;
        end
      end
    end
  end

  aes_sbox_lane #(
    .ENTRIES_PER_CYCLE(ENTRIES_PER_CYCLE),
    .CTR_W            (CTR_W)
  ) u_lane [NUM_LANES-1:0] (
    .clk    (clk),
    .we     (fill_we),
    .wr_bank(~bank_sel),
    .ctr    (ctr),
    .mc     (mc_q),
    .dir    (dir_q),
    .rd_bank(bank_sel),
    .addr   (addr_i),
    .rd_data(lane_rd)
  );

  assign data_o = active_valid_o ? lane_rd : '0;

endmodule

// File: tb/tb_aes_sbox_table_bank.sv
// Bench for aes_sbox_table_bank: random masks/addresses checked against a
// table-level model of active/shadow bank contents.

module tb_aes_sbox_table_bank;

  localparam int NL  = 16;
  localparam int EPC = 16;
  localparam int FC  = 256 / EPC;

  logic                clk;
  logic                rst_n;
  logic                start_i;
  logic                start_ready_o;
  logic                enc_dec_i;
  logic [NL-1:0][7:0]  mc_i;
  logic                abort_i;
  logic                swap_i;
  logic                busy_o;
  logic                fill_done_o;
  logic                shadow_ready_o;
  logic                active_valid_o;
  logic                active_dec_o;
  logic [NL-1:0][7:0]  addr_i;
  logic [NL-1:0][7:0]  data_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  // Model: contents of each bank described by (mask per lane, direction).
  logic [NL-1:0][7:0] act_mask, sh_mask, pend_mask;
  logic               act_dir, sh_dir, pend_dir, act_valid;

  aes_sbox_table_bank #(.NUM_LANES(NL), .ENTRIES_PER_CYCLE(EPC)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .start_ready_o(start_ready_o),
    .enc_dec_i(enc_dec_i), .mc_i(mc_i), .abort_i(abort_i), .swap_i(swap_i),
    .busy_o(busy_o), .fill_done_o(fill_done_o), .shadow_ready_o(shadow_ready_o),
    .active_valid_o(active_valid_o), .active_dec_o(active_dec_o),
    .addr_i(addr_i), .data_o(data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] v, b, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
      fwd_t[x] = b;
      inv_t[b] = 8'(x);
    end
  endtask

  function automatic logic [NL-1:0][7:0] exp_vec();
    logic [NL-1:0][7:0] v;
    logic [7:0] m;
    for (int j = 0; j < NL; j++) begin
      m = act_mask[j];
      v[j] = !act_valid ? 8'h00 : ((act_dir ? inv_t[addr_i[j] ^ m] : fwd_t[addr_i[j] ^ m]) ^ m);
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input logic [NL-1:0][7:0] m, input logic d);
    mc_i = m; enc_dec_i = d; start_i = 1'b1;
    step();
    start_i = 1'b0;
    pend_mask = m; pend_dir = d;
  endtask

  task automatic model_swap();
    act_mask = sh_mask; act_dir = sh_dir; act_valid = 1'b1;
  endtask

  task automatic wait_done(input int exp_n);
    int n = 0;
    while (!fill_done_o && n < 300) begin step(); n++; end
    total++;
    if (fill_done_o !== 1'b1) begin
      bad++; $display("FAIL fill_done_timeout got=%b want=1", fill_done_o);
    end
    total++;
    if (n != exp_n) begin
      bad++; $display("FAIL fill_latency got=%0d want=%0d", n, exp_n);
    end
    total++;
    if (busy_o !== 1'b0 || start_ready_o !== 1'b1) begin
      bad++; $display("FAIL done_idle busy=%b ready=%b want 0/1", busy_o, start_ready_o);
    end
    sh_mask = pend_mask; sh_dir = pend_dir;
  endtask

  task automatic do_swap();
    swap_i = 1'b1;
    step();
    swap_i = 1'b0;
    model_swap();
    total++;
    if (active_valid_o !== 1'b1 || active_dec_o !== act_dir || shadow_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL swap_flags valid=%b dec=%b sready=%b want 1/%b/0",
               active_valid_o, active_dec_o, shadow_ready_o, act_dir);
    end
  endtask

  task automatic sweep(input string name, input int n);
    for (int r = 0; r < n; r++) begin
      for (int j = 0; j < NL; j++) addr_i[j] = 8'($urandom);
      #1;
      total++;
      if (data_o !== exp_vec()) begin
        bad++; $display("FAIL %s addr=%h got=%h want=%h", name, addr_i, data_o, exp_vec());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start_i = 0; enc_dec_i = 0; mc_i = '0; abort_i = 0; swap_i = 0; addr_i = '0;
    act_valid = 0; act_dir = 0; act_mask = '0; sh_mask = '0; sh_dir = 0;
    #1 rst_n = 1'b0;
    #3;
    total++;
    if ({busy_o, fill_done_o, shadow_ready_o, active_valid_o, active_dec_o} !== 5'b0 ||
        start_ready_o !== 1'b1 || data_o !== '0) begin
      bad++; $display("FAIL reset_state flags=%b ready=%b data=%h",
        {busy_o, fill_done_o, shadow_ready_o, active_valid_o, active_dec_o}, start_ready_o, data_o);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    swap_i = 1'b1;
    step();
    swap_i = 1'b0;
    total++;
    if (active_valid_o !== 1'b0 || shadow_ready_o !== 1'b0) begin
      bad++; $display("FAIL idle_swap valid=%b sready=%b want 0/0", active_valid_o, shadow_ready_o);
    end
  endtask

  task automatic test_fill_zero_mask();
    logic [NL-1:0][7:0] a;
    start_fill('0, 1'b0);
    total++;
    if (busy_o !== 1'b1 || start_ready_o !== 1'b0) begin
      bad++; $display("FAIL accept busy=%b ready=%b want 1/0", busy_o, start_ready_o);
    end
    wait_done(FC);
    total++;
    if (shadow_ready_o !== 1'b1) begin
      bad++; $display("FAIL shadow_ready got=%b want=1", shadow_ready_o);
    end
    sweep("pre_swap_zero", 4);
    step();
    total++;
    if (fill_done_o !== 1'b0) begin
      bad++; $display("FAIL done_pulse_width got=%b want=0", fill_done_o);
    end
    do_swap();
    addr_i = {NL{8'h00}};
    #1 a = {NL{8'h63}};
    total++;
    if (data_o !== a) begin bad++; $display("FAIL sbox_00 got=%h want=%h", data_o, a); end
    addr_i = {NL{8'h53}};
    #1 a = {NL{8'hED}};
    total++;
    if (data_o !== a) begin bad++; $display("FAIL sbox_53 got=%h want=%h", data_o, a); end
    sweep("zero_mask_enc", 24);
  endtask

  task automatic test_lane_mask_dec();
    logic [NL-1:0][7:0] m;
    m = '0; m[3] = 8'h5A;
    start_fill(m, 1'b0);
    wait_done(FC);
    do_swap();
    addr_i = '0; addr_i[3] = 8'h5A;
    #1;
    total++;
    if (data_o[3] !== 8'h39) begin bad++; $display("FAIL lane3_masked got=%h want=39", data_o[3]); end
    sweep("lane3_mask", 16);
    start_fill('0, 1'b1);
    wait_done(FC);
    do_swap();
    addr_i = {NL{8'h63}};
    #1;
    total++;
    if (data_o !== '0 || active_dec_o !== 1'b1) begin
      bad++; $display("FAIL dec_63 got=%h dec=%b want 0/1", data_o, active_dec_o);
    end
    sweep("dec_zero_mask", 16);
  endtask

  task automatic test_refill_in_use();
    logic [NL-1:0][7:0] m;
    for (int j = 0; j < NL; j++) m[j] = 8'($urandom);
    start_fill(m, 1'($urandom));
    for (int k = 0; k < FC + 2; k++) begin
      sweep("in_use_old", 1);
      if (k < FC - 1) step();
      else if (k == FC - 1) wait_done(1);
    end
    do_swap();
    sweep("in_use_new", 24);
  endtask

  task automatic test_early_swap();
    logic [NL-1:0][7:0] m;
    logic old_dec;
    for (int j = 0; j < NL; j++) m[j] = 8'($urandom);
    old_dec = act_dir;
    start_fill(m, ~act_dir);
    step(); step();
    swap_i = 1'b1;
    step();
    swap_i = 1'b0;
    sweep("early_swap_hold", 2);
    total++;
    if (active_dec_o !== old_dec || shadow_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL early_swap_hold dec=%b sready=%b busy=%b", active_dec_o, shadow_ready_o, busy_o);
    end
    wait_done(FC - 3);
    model_swap();
    total++;
    if (shadow_ready_o !== 1'b0 || active_dec_o !== act_dir) begin
      bad++; $display("FAIL early_swap_exec sready=%b dec=%b want 0/%b", shadow_ready_o, active_dec_o, act_dir);
    end
    sweep("early_swap_new", 24);
  endtask

  task automatic test_abort();
    logic [NL-1:0][7:0] m;
    bit seen = 0;
    for (int j = 0; j < NL; j++) m[j] = 8'($urandom);
    start_fill(m, 1'($urandom));
    for (int k = 0; k < 4; k++) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || shadow_ready_o !== 1'b0) begin
      bad++; $display("FAIL abort_idle busy=%b sready=%b want 0/0", busy_o, shadow_ready_o);
    end
    for (int k = 0; k < FC + 4; k++) begin
      if (fill_done_o) seen = 1;
      step();
    end
    total++;
    if (seen) begin bad++; $display("FAIL abort_no_done got=1 want=0"); end
    swap_i = 1'b1;
    step();
    swap_i = 1'b0;
    sweep("abort_active_kept", 8);
    total++;
    if (active_valid_o !== 1'b1 || active_dec_o !== act_dir) begin
      bad++; $display("FAIL abort_active valid=%b dec=%b want 1/%b", active_valid_o, active_dec_o, act_dir);
    end
    mc_i = m; start_i = 1'b1; abort_i = 1'b1;
    step();
    start_i = 1'b0; abort_i = 1'b0;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL start_with_abort busy=%b want=0", busy_o); end
    for (int j = 0; j < NL; j++) m[j] = 8'($urandom);
    start_fill(m, 1'($urandom));
    wait_done(FC);
    do_swap();
    sweep("after_abort_fill", 16);
  endtask

  task automatic test_back_to_back();
    logic [NL-1:0][7:0] m1, m2;
    for (int j = 0; j < NL; j++) begin m1[j] = 8'($urandom); m2[j] = 8'($urandom); end
    start_fill(m1, 1'b0);
    wait_done(FC);
    swap_i = 1'b1;
    start_fill(m2, 1'b1);
    swap_i = 1'b0;
    model_swap();
    total++;
    if (busy_o !== 1'b1 || active_dec_o !== 1'b0 || shadow_ready_o !== 1'b0) begin
      bad++; $display("FAIL start_swap busy=%b dec=%b sready=%b want 1/0/0", busy_o, active_dec_o, shadow_ready_o);
    end
    for (int k = 0; k < FC - 1; k++) begin sweep("b2b_during", 1); step(); end
    wait_done(1);
    sweep("b2b_before_swap", 8);
    do_swap();
    sweep("b2b_new", 16);
  endtask

  task automatic test_reset_and_mask_hold();
    logic [NL-1:0][7:0] m, junk;
    for (int j = 0; j < NL; j++) m[j] = 8'($urandom);
    start_fill(m, 1'b0);
    for (int k = 0; k < 7; k++) step();
    #2 rst_n = 1'b0;
    #1;
    act_valid = 1'b0;
    total++;
    if ({busy_o, fill_done_o, shadow_ready_o, active_valid_o, active_dec_o} !== 5'b0 || data_o !== '0) begin
      bad++; $display("FAIL async_reset flags=%b data=%h want 0",
        {busy_o, fill_done_o, shadow_ready_o, active_valid_o, active_dec_o}, data_o);
    end
    #2 rst_n = 1'b1;
    step();
    for (int j = 0; j < NL; j++) begin m[j] = 8'($urandom); junk[j] = ~m[j]; end
    start_fill(m, 1'b1);
    mc_i = junk; enc_dec_i = 1'b0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_done(FC - 1);
    do_swap();
    sweep("mask_sampled_at_accept", 24);
  endtask

  initial begin
    build_tables();
    test_reset();
    test_fill_zero_mask();
    test_lane_mask_dec();
    test_refill_in_use();
    test_early_swap();
    test_abort();
    test_back_to_back();
    test_reset_and_mask_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
